// File: rtl/tinychip_pkg.sv
// Shared types for the tinychip datapath: register-file word/address types and
// the register-file access controller state encoding.
package tinychip_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned RADDR_W = 2;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [RADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } rac_state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Initiator for the 4x16 register file: arbitrates operand-fetch reads against
// writeback writes, absorbs the file's registered read latency and hands operand pairs on.
module regfile_access_ctrl
  import tinychip_pkg::*;
#(
  parameter int unsigned DATA_W       = WORD_W,
  parameter int unsigned ADDR_W       = RADDR_W,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_src1,
  input  logic [ADDR_W-1:0] rd_src2,
  output logic              rd_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] rf_reg1,
  output logic [ADDR_W-1:0] rf_reg2,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  rac_state_e          r_state;
  rac_state_e          w_next_state;
  logic [ADDR_W-1:0]   r_src1;
  logic [ADDR_W-1:0]   r_src2;
  logic [STARVE_W-1:0] r_starve;
  logic                r_op_valid;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;

  logic w_slot_free;
  logic w_starved;
  logic w_rd_grant;
  logic w_wb_grant;

  // A new read may start only when the output slot is empty or drains this cycle.
  assign w_slot_free = (r_state == IDLE) && (!r_op_valid || op_ready);
  assign w_starved   = (r_starve == STARVE_W'(STARVE_LIMIT));
  assign w_rd_grant  = rd_valid && rd_ready;
  assign w_wb_grant  = wb_valid && wb_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_rd_grant) w_next_state = ISSUE;
      ISSUE:   w_next_state = CAPTURE;
      CAPTURE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Port arbitration: writes win unless the waiting read has been starved too long.
  always_comb begin
    rd_ready      = 1'b0;
    wb_ready      = 1'b0;
    rf_reg1       = r_src1;
    rf_reg2       = r_src2;
    rf_write      = 1'b0;
    rf_write_data = '0;
    if (reset) begin
      rf_reg1 = '0;
      rf_reg2 = '0;
    end else begin
      rd_ready = w_slot_free && (!wb_valid || w_starved);
      wb_ready = (r_state != ISSUE) && !(rd_valid && rd_ready);
      if (wb_valid && wb_ready) begin
        rf_write      = 1'b1;
        rf_reg1       = wb_dest;
        rf_write_data = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src1     <= '0;
      r_src2     <= '0;
      r_starve   <= '0;
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
    end else begin
      if (w_rd_grant) begin
        r_src1 <= rd_src1;
        r_src2 <= rd_src2;
      end
      // Count only cycles where a read could have started but lost to a write.
      if (w_rd_grant) begin
        r_starve <= '0;
      end else if (w_slot_free && rd_valid && w_wb_grant && !w_starved) begin
        r_starve <= r_starve + STARVE_W'(1);
      end
      if (r_state == CAPTURE) begin
        r_op_a     <= rf_data1;
        r_op_b     <= rf_data2;
        r_op_valid <= 1'b1;
      end else if (r_op_valid && op_ready) begin
        r_op_valid <= 1'b0;
      end
    end
  end

  assign op_valid = r_op_valid;
  assign op_a     = r_op_a;
  assign op_b     = r_op_b;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: 4-entry register file model, directed scenarios,
// then randomized traffic checked by a transaction-level reference model and scoreboard.
module tb_regfile_access_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 2;
  localparam int          LIMIT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_valid;
  logic [AW-1:0] rd_src1;
  logic [AW-1:0] rd_src2;
  logic          rd_ready;
  logic          wb_valid;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic          wb_ready;
  logic          op_valid;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          op_ready;
  logic [AW-1:0] rf_reg1;
  logic [AW-1:0] rf_reg2;
  logic          rf_write;
  logic [DW-1:0] rf_write_data;
  logic [DW-1:0] rf_data1 = '0;
  logic [DW-1:0] rf_data2 = '0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_src1(rd_src1), .rd_src2(rd_src2), .rd_ready(rd_ready),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ready(wb_ready),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_write(rf_write),
    .rf_write_data(rf_write_data), .rf_data1(rf_data1), .rf_data2(rf_data2)
  );

  // Register file: writes commit on negedge, reads are registered on posedge.
  logic [DW-1:0] rf_mem [4] = '{default: '0};
  always @(negedge clk) if (rf_write) rf_mem[rf_reg1] <= rf_write_data;
  always @(posedge clk) begin
    rf_data1 <= rf_mem[rf_reg1];
    rf_data2 <= rf_mem[rf_reg2];
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            due;
  } pair_t;

  pair_t         sb_q[$];
  int            edge_cnt = 0;
  logic          s_valid  = 1'b0;
  logic [DW-1:0] s_a      = '0;
  logic [DW-1:0] s_b      = '0;

  // Reference model: architectural register contents, read in flight, starvation count.
  logic [DW-1:0] m_rf [4] = '{default: '0};
  int            m_busy   = 0;
  int            m_starve = 0;
  logic [AW-1:0] m_src1   = '0;
  logic [AW-1:0] m_src2   = '0;
  logic          m_slot_free, m_rd, m_wb, m_wr, m_acc;
  pair_t         m_pair;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_rd_ready", 32'(rd_ready), 32'd0);
      chk("rst_wb_ready", 32'(wb_ready), 32'd0);
      chk("rst_rf_write", 32'(rf_write), 32'd0);
      chk("rst_rf_reg1", 32'(rf_reg1), 32'd0);
      chk("rst_rf_reg2", 32'(rf_reg2), 32'd0);
      m_busy   = 0;
      m_starve = 0;
      m_src1   = '0;
      m_src2   = '0;
    end else begin
      m_slot_free = (m_busy == 0) && (!s_valid || op_ready);
      m_rd  = m_slot_free && (!wb_valid || m_starve == LIMIT);
      m_wb  = (m_busy != 2) && !(rd_valid && m_rd);
      m_wr  = wb_valid && m_wb;
      m_acc = rd_valid && m_rd;
      chk("rd_ready", 32'(rd_ready), 32'(m_rd));
      chk("wb_ready", 32'(wb_ready), 32'(m_wb));
      chk("rf_write", 32'(rf_write), 32'(m_wr));
      chk("rf_reg1", 32'(rf_reg1), 32'(m_wr ? wb_dest : m_src1));
      chk("rf_reg2", 32'(rf_reg2), 32'(m_src2));
      if (m_wr) begin
        chk("rf_write_data", 32'(rf_write_data), 32'(wb_data));
        m_rf[wb_dest] = wb_data;
      end
      if (m_acc) begin
        m_pair.a   = m_rf[rd_src1];
        m_pair.b   = m_rf[rd_src2];
        m_pair.due = edge_cnt + 2;
        sb_q.push_back(m_pair);
        m_src1   = rd_src1;
        m_src2   = rd_src2;
        m_busy   = 2;
        m_starve = 0;
      end else if (m_busy > 0) begin
        m_busy--;
      end else if (rd_valid && wb_valid && m_slot_free && m_starve < LIMIT) begin
        m_starve++;
      end
    end
  end

  // Scoreboard: expected output slot advances on each clock edge.
  pair_t pop_p;
  always @(posedge clk) begin
    if (reset) begin
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
      sb_q.delete();
    end else begin
      if (s_valid && op_ready) s_valid = 1'b0;
      if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
        pop_p   = sb_q.pop_front();
        s_a     = pop_p.a;
        s_b     = pop_p.b;
        s_valid = 1'b1;
      end
    end
    edge_cnt++;
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("op_valid", 32'(op_valid), 32'(s_valid));
      if (s_valid) begin
        chk("op_a", 32'(op_a), 32'(s_a));
        chk("op_b", 32'(op_b), 32'(s_b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_op(output int lat);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (op_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("op_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic write1(input logic [AW-1:0] d, input logic [DW-1:0] v);
    wb_valid = 1'b1;
    wb_dest  = d;
    wb_data  = v;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic read1(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    rd_valid = 1'b1;
    rd_src1  = s1;
    rd_src2  = s2;
    step();
    rd_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc_n, w_before, w_between;
    reset = 1'b1; rd_valid = 1'b0; rd_src1 = '0; rd_src2 = '0;
    wb_valid = 1'b0; wb_dest = '0; wb_data = '0; op_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_op_valid", 32'(op_valid), 32'd0);
    chk("reset_op_a", 32'(op_a), 32'd0);
    chk("reset_op_b", 32'(op_b), 32'd0);
    step();

    // Basic write then read, with latency measured in negedges after the accept edge.
    write1(2'd2, 16'hBEEF);
    read1(2'd2, 2'd0);
    wait_op(lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_op_a", 32'(op_a), 32'hBEEF);
    chk("t1_op_b", 32'(op_b), 32'h0000);
    step();

    // Continuous contention: three write wins per read, plus the write taken in CAPTURE.
    rd_valid = 1'b1; rd_src1 = 2'd1; rd_src2 = 2'd2;
    wb_valid = 1'b1; wb_dest = 2'd2; wb_data = 16'h0101;
    acc_n = 0; w_before = 0; w_between = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) acc_n++;
      else if (rf_write) begin
        if (acc_n == 0) w_before++;
        else if (acc_n == 1) w_between++;
      end
      step();
      wb_dest = 2'(2 + $urandom_range(0, 1));
      wb_data = 16'($urandom);
    end
    rd_valid = 1'b0; wb_valid = 1'b0;
    chk("t2_writes_before_read", 32'(w_before), 32'd3);
    chk("t2_writes_between_reads", 32'(w_between), 32'd4);
    chk("t2_read_accepts", 32'(acc_n), 32'd3);
    repeat (4) step();

    // Write during CAPTURE is not seen by the in-flight read.
    write1(2'd1, 16'h5555);
    rd_valid = 1'b1; rd_src1 = 2'd1; rd_src2 = 2'd0;
    step();
    rd_valid = 1'b0;
    step();
    write1(2'd1, 16'h1234);
    wait_op(lat);
    chk("t3_old_r1", 32'(op_a), 32'h5555);
    step();
    read1(2'd1, 2'd1);
    wait_op(lat);
    chk("t3_new_r1_a", 32'(op_a), 32'h1234);
    chk("t3_new_r1_b", 32'(op_b), 32'h1234);
    step();

    // Backpressure: operands hold, reads blocked, writes still accepted.
    write1(2'd2, 16'hA5A5);
    write1(2'd3, 16'h5A5A);
    op_ready = 1'b0;
    read1(2'd2, 2'd3);
    wait_op(lat);
    step();
    for (int i = 0; i < 5; i++) begin
      rd_valid = 1'b1; rd_src1 = 2'd0; rd_src2 = 2'd0;
      wb_valid = 1'b1; wb_dest = 2'd2; wb_data = 16'($urandom);
      @(negedge clk);
      chk("t4_op_valid_hold", 32'(op_valid), 32'd1);
      chk("t4_op_a_hold", 32'(op_a), 32'hA5A5);
      chk("t4_op_b_hold", 32'(op_b), 32'h5A5A);
      chk("t4_rd_blocked", 32'(rd_ready), 32'd0);
      chk("t4_wb_accepted", 32'(wb_ready), 32'd1);
      step();
    end
    wb_valid = 1'b0; op_ready = 1'b1;
    step();
    rd_valid = 1'b0;
    wait_op(lat);
    step();

    // Reset during ISSUE drops the read and suppresses a pending write.
    read1(2'd1, 2'd1);
    reset = 1'b1; wb_valid = 1'b1; wb_dest = 2'd0; wb_data = 16'hDEAD;
    @(negedge clk);
    chk("t5_rf_write_in_reset", 32'(rf_write), 32'd0);
    step();
    reset = 1'b0; wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_capture", 32'(op_valid), 32'd0);
      chk("t5_idle_ready", 32'(rd_ready), 32'd1);
      step();
    end
    read1(2'd1, 2'd0);
    wait_op(lat);
    chk("t5_latency", 32'(lat), 32'd3);
    chk("t5_op_a", 32'(op_a), 32'h1234);
    chk("t5_op_b", 32'(op_b), 32'h0000);
    step();

    // Same source for both operands.
    write1(2'd3, 16'hFFFF);
    read1(2'd3, 2'd3);
    wait_op(lat);
    chk("t6_op_a", 32'(op_a), 32'hFFFF);
    chk("t6_op_b", 32'(op_b), 32'hFFFF);
    step();

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      rd_valid = ($urandom_range(0, 9) < 6);
      rd_src1  = 2'($urandom);
      rd_src2  = 2'($urandom);
      wb_valid = ($urandom_range(0, 9) < 5);
      wb_dest  = 2'($urandom);
      wb_data  = 16'($urandom);
      op_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    reset = 1'b0; rd_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("final_op_valid", 32'(op_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
